mem_line_arbiter: RTL and testbench

- Shares the single main-memory word port between the instruction-cache and data-cache controllers.
- Each requester asks for one whole-line transfer: a refill (read) or a writeback (write).
- The arbiter grants one requester at a time and sequences the line as WORDS_PER_LINE single-word memory beats. It returns per-beat data/strobes and a one-cycle done pulse.
- It sits between the cache controllers' REFILL/writeback states and the memory model.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_beat_counter.sv | 43 ++++
 rtl/mem_line_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_line_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default line geometry for the memory line arbiter
package mem_arb_pkg;

  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } requester_t;

  // Number of byte-offset bits covered by one cache line.
  function automatic int line_off_bits(input int words, input int data_w);
    return $clog2(words) + $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// rtl/mem_beat_counter.sv - line-base latch and beat counter producing per-beat word addresses
module mem_beat_counter
  import mem_arb_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load,
  input  logic [ADDR_W-1:0]                 addr,
  input  logic                              inc,
  output logic [$clog2(WORDS_PER_LINE)-1:0] cnt,
  output logic [ADDR_W-1:0]                 beat_addr,
  output logic                              last
);

  localparam int CNT_W      = $clog2(WORDS_PER_LINE);
  localparam int WORD_OFF_W = $clog2(DATA_W / 8);
  localparam int LINE_OFF_W = line_off_bits(WORDS_PER_LINE, DATA_W);
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << LINE_OFF_W) - ADDR_W'(1));

  logic [ADDR_W-1:0] line_base;

  // Latch the aligned line base on load; advance the beat index, holding at the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base <= '0;
      cnt       <= '0;
    end else if (load) begin
      line_base <= addr & LINE_MASK;
      cnt       <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last      = (cnt == CNT_W'(WORDS_PER_LINE - 1));
  assign beat_addr = line_base | (ADDR_W'(cnt) << WORD_OFF_W);

endmodule

// File: rtl/mem_line_arbiter.sv
// rtl/mem_line_arbiter.sv - I/D-cache line arbiter onto one memory word port; MEM_LINE_ARB_FIXED_PRIO_EN gives the D-cache fixed priority
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W
) (
  input  logic                              CLK,
  input  logic                              reset_n,
  input  logic                              ic_req,
  input  logic [ADDR_W-1:0]                 ic_addr,
  output logic [DATA_W-1:0]                 ic_rdata,
  output logic                              ic_rvalid,
  output logic                              ic_done,
  input  logic                              dc_req,
  input  logic                              dc_we,
  input  logic [ADDR_W-1:0]                 dc_addr,
  input  logic [DATA_W-1:0]                 dc_wdata,
  output logic [$clog2(WORDS_PER_LINE)-1:0] dc_widx,
  output logic [DATA_W-1:0]                 dc_rdata,
  output logic                              dc_rvalid,
  output logic                              dc_done,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  input  logic                              mem_ack,
  output logic                              busy
);

  arb_state_t state;
  requester_t owner;
  requester_t last_grant;
  requester_t pick;
  logic       line_we;
  logic       grant;
  logic       xfer;
  logic       rd_ack;
  logic       last;
  logic [$clog2(WORDS_PER_LINE)-1:0] cnt;
  logic [ADDR_W-1:0]                 beat_addr;

  assign grant = (state == IDLE) && (ic_req || dc_req);
  assign xfer  = (state == XFER);

  // Choose the winner among pending requests for this IDLE cycle.
  always_comb begin
    pick = ICACHE;
    if (dc_req && !ic_req) begin
      pick = DCACHE;
    end else if (dc_req && ic_req) begin
`ifdef MEM_LINE_ARB_FIXED_PRIO_EN
      pick = DCACHE;
`else
      pick = (last_grant == ICACHE) ? DCACHE : ICACHE;
`endif
    end
  end

  // Line sequencing: grant in IDLE, one beat per ack in XFER, single DONE cycle.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= ICACHE;
      line_we    <= 1'b0;
      last_grant <= DCACHE;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            owner   <= pick;
            line_we <= (pick == DCACHE) && dc_we;
            state   <= XFER;
          end
        end
        XFER: begin
          if (mem_ack && last) begin
            state <= DONE;
          end
        end
        DONE: begin
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_beat_counter #(
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W)
  ) u_beat_counter (
    .clk      (CLK),
    .rst_n    (reset_n),
    .load     (grant),
    .addr     ((pick == DCACHE) ? dc_addr : ic_addr),
    .inc      (xfer && mem_ack),
    .cnt      (cnt),
    .beat_addr(beat_addr),
    .last     (last)
  );

  // Outputs are gated by state so an asynchronous reset forces them all to zero.
  assign rd_ack    = xfer && mem_ack && !line_we;
  assign mem_req   = xfer;
  assign mem_we    = xfer && line_we;
  assign mem_addr  = xfer ? beat_addr : '0;
  assign mem_wdata = xfer ? dc_wdata : '0;
  assign dc_widx   = xfer ? cnt : '0;

  assign ic_rvalid = rd_ack && (owner == ICACHE);
  assign dc_rvalid = rd_ack && (owner == DCACHE);
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;

  assign ic_done = (state == DONE) && (owner == ICACHE);
  assign dc_done = (state == DONE) && (owner == DCACHE);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb/tb_mem_line_arbiter.sv - directed table-driven bench for mem_line_arbiter
module tb_mem_line_arbiter;

  localparam int W  = 8;
  localparam int AW = 32;
  localparam int DW = 32;

`ifdef MEM_LINE_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          reset_n = 1'b0;
  logic          ic_req = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic [DW-1:0] ic_rdata;
  logic          ic_rvalid;
  logic          ic_done;
  logic          dc_req = 1'b0;
  logic          dc_we = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [DW-1:0] dc_wdata = '0;
  logic [2:0]    dc_widx;
  logic [DW-1:0] dc_rdata;
  logic          dc_rvalid;
  logic          dc_done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          busy;

  always #5 CLK = ~CLK;

  mem_line_arbiter #(.WORDS_PER_LINE(W), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .reset_n(reset_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_widx(dc_widx),
    .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  typedef struct {
    logic        ic;
    logic        dc;
    logic        dc_we;
    logic [31:0] ic_addr;
    logic [31:0] dc_addr;
    int          wait_cyc;
    int          late_dc;
    logic        exp_owner;
    logic [31:0] exp_base;
    logic        exp_we;
    int          exp_cycles;
  } row_t;

  int checks = 0;
  int errors = 0;
  int ack_wait = 0;
  int wc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model: acks after ack_wait idle cycles per beat; read data encodes the address.
  task automatic respond();
    if (mem_req) begin
      if (wc == ack_wait) begin
        mem_ack = 1'b1;
        wc = 0;
      end else begin
        mem_ack = 1'b0;
        wc++;
      end
    end else begin
      mem_ack = 1'b0;
      wc = 0;
    end
    mem_rdata = mem_ack ? (32'hD000_0000 | mem_addr) : 32'hDEAD_BEEF;
    dc_wdata  = 32'hA0 + 32'(dc_widx);
    #1;
  endtask

  task automatic step();
    @(negedge CLK);
    respond();
  endtask

  task automatic run_row(input int r, input row_t v);
    int beat, n, done_at, rv_own, rv_oth, done_oth;
    logic [31:0] ea;
    logic [31:0] own_rdata;
    beat = 0; n = 0; done_at = 0; rv_own = 0; rv_oth = 0; done_oth = 0;
    ack_wait = v.wait_cyc;
    @(negedge CLK);
    ic_req = v.ic; dc_req = v.dc; dc_we = v.dc_we; ic_addr = v.ic_addr; dc_addr = v.dc_addr;
    while (done_at == 0 && n < 200) begin
      if (n > 0) @(negedge CLK);
      respond();
      n++;
      ea = v.exp_base + 32'(beat) * 32'd4;
      own_rdata = v.exp_owner ? dc_rdata : ic_rdata;
      if (mem_req && mem_ack) begin
        chk($sformatf("row%0d beat%0d addr", r, beat), mem_addr, ea);
        chk($sformatf("row%0d beat%0d we", r, beat), 32'(mem_we), 32'(v.exp_we));
        if (v.exp_we)
          chk($sformatf("row%0d beat%0d wdata", r, beat), mem_wdata, 32'hA0 + 32'(beat));
        else
          chk($sformatf("row%0d beat%0d rdata", r, beat), own_rdata, 32'hD000_0000 | ea);
        beat++;
      end else if (mem_req) begin
        chk($sformatf("row%0d beat%0d hold addr", r, beat), mem_addr, ea);
      end
      if (v.exp_owner ? dc_rvalid : ic_rvalid) rv_own++;
      if (v.exp_owner ? ic_rvalid : dc_rvalid) rv_oth++;
      if (v.exp_owner ? ic_done : dc_done) done_oth++;
      if (v.exp_owner ? dc_done : ic_done) begin
        done_at = n;
        if (v.exp_owner) dc_req = 1'b0;
        else ic_req = 1'b0;
      end
      if (v.late_dc != 0 && n == v.late_dc) dc_req = 1'b1;
    end
    chk($sformatf("row%0d beats", r), 32'(beat), 32'(W));
    chk($sformatf("row%0d owner rvalids", r), 32'(rv_own), v.exp_we ? 32'd0 : 32'(W));
    chk($sformatf("row%0d other rvalids", r), 32'(rv_oth), 32'd0);
    chk($sformatf("row%0d other done", r), 32'(done_oth), 32'd0);
    chk($sformatf("row%0d done cycle", r), 32'(done_at), 32'(v.exp_cycles));
  endtask

  row_t rows [9];

  initial begin
    int b, n;
    rows[0] = '{1'b1, 1'b1, 1'b0, 32'h3000, 32'h4004, 0, 0, FP,   FP ? 32'h4000 : 32'h3000, 1'b0, 10};
    rows[1] = '{1'b1, 1'b1, 1'b0, 32'h3000, 32'h4004, 0, 0, 1'b1, 32'h4000, 1'b0, 10};
    rows[2] = '{1'b1, 1'b1, 1'b0, 32'h3000, 32'h4004, 0, 0, FP,   FP ? 32'h4000 : 32'h3000, 1'b0, 10};
    rows[3] = '{1'b1, 1'b1, 1'b0, 32'h3000, 32'h4004, 0, 0, 1'b1, 32'h4000, 1'b0, 10};
    rows[4] = '{1'b1, 1'b0, 1'b0, 32'h1234, 32'h0,    0, 0, 1'b0, 32'h1220, 1'b0, 10};
    rows[5] = '{1'b0, 1'b1, 1'b1, 32'h0,    32'h2000, 0, 0, 1'b1, 32'h2000, 1'b1, 10};
    rows[6] = '{1'b1, 1'b0, 1'b0, 32'h5010, 32'h0,    3, 0, 1'b0, 32'h5000, 1'b0, 34};
    rows[7] = '{1'b1, 1'b0, 1'b0, 32'h1234, 32'h6008, 0, 4, 1'b0, 32'h1220, 1'b0, 10};
    rows[8] = '{1'b0, 1'b1, 1'b0, 32'h0,    32'h6008, 0, 0, 1'b1, 32'h6000, 1'b0, 10};

    // Reset state: requests asserted during reset must not produce activity.
    ic_req = 1'b1; dc_req = 1'b1; ic_addr = 32'h1234; dc_addr = 32'h2000;
    repeat (2) step();
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ic_done", 32'(ic_done), 32'd0);
    chk("rst dc_done", 32'(dc_done), 32'd0);
    chk("rst dc_widx", 32'(dc_widx), 32'd0);
    ic_req = 1'b0; dc_req = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_row(i, rows[i]);

    // Reset in the middle of a refill, at beat 4.
    ack_wait = 0;
    @(negedge CLK);
    ic_req = 1'b1; dc_req = 1'b0; ic_addr = 32'h7000;
    respond();
    b = 0; n = 0;
    while (b < 4 && n < 50) begin
      step();
      n++;
      if (mem_req && mem_ack) b++;
    end
    step();
    chk("midrst beat4 addr", mem_addr, 32'h7010);
    chk("midrst busy before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    ic_req = 1'b0;
    #1;
    chk("midrst mem_req async", 32'(mem_req), 32'd0);
    chk("midrst mem_addr async", mem_addr, 32'd0);
    chk("midrst busy async", 32'(busy), 32'd0);
    chk("midrst ic_rvalid async", 32'(ic_rvalid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("midrst no done %0d", k), 32'(ic_done), 32'd0);
    end
    reset_n = 1'b1;
    run_row(9, '{1'b1, 1'b0, 1'b0, 32'h7000, 32'h0, 0, 0, 1'b0, 32'h7000, 1'b0, 10});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
